// File: rtl/data_c_pipe_sync_tap.sv
`default_nettype none
// ============================================================================
//  Module      : data_c_pipe_sync_tap
//  Description : LAT-stage valid/ready register pipeline with per-stage taps
//                and a registered occupancy counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_c_pipe_sync_tap #(
    parameter int LAT   = 4,
    parameter int DSIZE = 32
) (
    input  logic                       clock,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [DSIZE-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [DSIZE-1:0]           out_data,
    input  logic                       out_ready,
    output logic [LAT-1:0][DSIZE-1:0]  tap_datas,
    output logic [LAT-1:0]             tap_valids,
    output logic [$clog2(LAT+1)-1:0]   occupancy
);

    localparam int                 c_occ_w   = $clog2(LAT + 1);
    localparam logic [c_occ_w-1:0] c_occ_one = 1;

    logic [LAT-1:0][DSIZE-1:0] r_data;
    logic [LAT-1:0]            r_vld;
    logic [c_occ_w-1:0]        r_occ;

    logic [LAT:0]              w_rdy;
    logic [LAT-1:0]            w_up_vld;
    logic [LAT-1:0][DSIZE-1:0] w_up_data;
    logic                      w_in_xfer;
    logic                      w_out_xfer;

    // Ready ripples back from the sink: a stage can take a beat if it is
    // empty or its own beat moves on this cycle.
    always_comb begin
        w_rdy      = '0;
        w_rdy[LAT] = out_ready;
        for (int k = LAT - 1; k >= 0; k--) begin
            w_rdy[k] = !r_vld[k] || w_rdy[k+1];
        end
    end

    always_comb begin
        w_up_vld     = '0;
        w_up_data    = '0;
        w_up_vld[0]  = in_valid;
        w_up_data[0] = in_data;
        for (int k = 1; k < LAT; k++) begin
            w_up_vld[k]  = r_vld[k-1];
            w_up_data[k] = r_data[k-1];
        end
    end

    assign in_ready   = w_rdy[0] && !flush;
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = r_vld[LAT-1] && out_ready;

    // Payload registers only move on a load; flush and drain touch valids only.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_vld  <= '0;
            r_data <= '0;
        end else if (flush) begin
            r_vld <= '0;
        end else begin
            for (int k = 0; k < LAT; k++) begin
                if (w_rdy[k]) begin
                    r_vld[k] <= w_up_vld[k];
                    if (w_up_vld[k]) begin
                        r_data[k] <= w_up_data[k];
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_occ <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else if (w_in_xfer && !w_out_xfer) begin
            r_occ <= r_occ + c_occ_one;
        end else if (!w_in_xfer && w_out_xfer) begin
            r_occ <= r_occ - c_occ_one;
        end
    end

    assign out_valid  = r_vld[LAT-1];
    assign out_data   = r_data[LAT-1];
    assign tap_datas  = r_data;
    assign tap_valids = r_vld;
    assign occupancy  = r_occ;

endmodule
`default_nettype wire

// File: tb/tb_data_c_pipe_sync_tap.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_c_pipe_sync_tap
//  Description : Randomised and directed self-checking bench for the tapped
//                pipeline, against a beat-position queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_c_pipe_sync_tap;

    localparam int LAT   = 4;
    localparam int DSIZE = 32;
    localparam int OW    = $clog2(LAT + 1);

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      flush;
    logic                      in_valid;
    logic [DSIZE-1:0]          in_data;
    logic                      in_ready;
    logic                      out_valid;
    logic [DSIZE-1:0]          out_data;
    logic                      out_ready;
    logic [LAT-1:0][DSIZE-1:0] tap_datas;
    logic [LAT-1:0]            tap_valids;
    logic [OW-1:0]             occupancy;

    data_c_pipe_sync_tap #(.LAT(LAT), .DSIZE(DSIZE)) dut (
        .clock      (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .tap_datas  (tap_datas),
        .tap_valids (tap_valids),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: each live beat is a (position, data) pair, oldest first.
    int                        m_pos[$];
    logic [DSIZE-1:0]          m_dat[$];
    logic [LAT-1:0][DSIZE-1:0] m_tap;
    logic [DSIZE-1:0]          sb[$];
    int                        p_new[$];
    bit                        p_leave;
    bit                        p_rdy;
    bit                        stall;
    logic [DSIZE-1:0]          prev_data;

    function automatic void model_reset();
        m_pos.delete();
        m_dat.delete();
        sb.delete();
        m_tap = '0;
        stall = 1'b0;
    endfunction

    // A beat advances unless the slot ahead is still held after the beat
    // in front of it has moved; the oldest leaves when the sink accepts.
    function automatic void plan(bit fl, bit ordy);
        int prev;
        p_new.delete();
        prev = LAT + 1;
        for (int i = 0; i < m_pos.size(); i++) begin
            int p;
            int n;
            p = m_pos[i];
            if (fl)          n = (p == LAT - 1 && ordy) ? LAT : p;
            else if (i == 0) n = (p == LAT - 1 && !ordy) ? p : p + 1;
            else             n = (prev == p + 1) ? p : p + 1;
            p_new.push_back(n);
            prev = n;
        end
        p_leave = (p_new.size() > 0) && (p_new[0] == LAT);
        p_rdy   = !fl && ((m_pos.size() == 0) || (p_new[p_new.size()-1] != 0));
    endfunction

    function automatic void apply(bit iv, logic [DSIZE-1:0] d, bit fl);
        if (fl) begin
            m_pos.delete();
            m_dat.delete();
            sb.delete();
        end else begin
            if (p_leave) begin
                void'(m_pos.pop_front());
                void'(m_dat.pop_front());
                void'(p_new.pop_front());
            end
            for (int i = 0; i < m_pos.size(); i++) begin
                if (p_new[i] != m_pos[i]) m_tap[p_new[i]] = m_dat[i];
                m_pos[i] = p_new[i];
            end
            if (iv && p_rdy) begin
                m_pos.push_back(0);
                m_dat.push_back(d);
                m_tap[0] = d;
            end
        end
    endfunction

    task automatic check_outputs();
        logic [LAT-1:0] ev;
        ev = '0;
        foreach (m_pos[i]) ev[m_pos[i]] = 1'b1;
        chk("out_valid", out_valid, ev[LAT-1]);
        if (ev[LAT-1]) chk("out_data", out_data, m_tap[LAT-1]);
        chk("occupancy", occupancy, m_pos.size());
        chk("tap_valids", tap_valids, ev);
        chk("tap_datas", tap_datas, m_tap);
        chk("occ_popcount", occupancy, $countones(tap_valids));
        if (stall) begin
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_data", out_data, prev_data);
        end
    endtask

    // Entered and left one time unit after a rising edge.
    task automatic step(bit iv, logic [DSIZE-1:0] d, bit fl, bit ordy);
        in_valid  = iv;
        in_data   = d;
        flush     = fl;
        out_ready = ordy;
        #1;
        plan(fl, ordy);
        chk("in_ready", in_ready, p_rdy);
        if (out_valid && out_ready) begin
            if (sb.size() == 0) chk("order_extra", out_valid, 1'b0);
            else                chk("order", out_data, sb.pop_front());
        end
        if (iv && p_rdy) sb.push_back(d);
        stall     = out_valid && !ordy && !fl;
        prev_data = out_data;
        @(posedge clk);
        #1;
        apply(iv, d, fl);
        check_outputs();
    endtask

    initial begin
        int first;
        int idx;
        bit take;

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_outputs();

        // Single beat latency through an empty pipe
        first = -1;
        step(1'b1, 32'hA5A5_A5A5, 1'b0, 1'b1);
        for (int c = 1; c <= 6; c++) begin
            if (out_valid && first < 0) first = c;
            if (c <= 4) chk("occ_single", occupancy, 1);
            if (c < 6) step(1'b0, '0, 1'b0, 1'b1);
        end
        chk("latency", first, 4);

        // Back-to-back stream
        for (int i = 0; i < 16; i++) step(1'b1, i, 1'b0, 1'b1);
        for (int i = 0; i < LAT + 1; i++) step(1'b0, '0, 1'b0, 1'b1);

        // Backpressure: six beats offered into a stalled sink
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            take = (idx < 6);
            step(take, idx, 1'b0, 1'b0);
            if (take && p_rdy) idx++;
        end
        chk("bp_accepted", idx, 4);
        chk("bp_occ", occupancy, 4);
        chk("bp_taps", tap_valids, 4'b1111);
        for (int k = 0; k < LAT; k++) chk("bp_tapdata", tap_datas[k], 3 - k);
        for (int c = 0; c < 12; c++) begin
            take = (idx < 6);
            step(take, idx, 1'b0, 1'b1);
            if (take && p_rdy) idx++;
        end
        chk("bp_all_sent", idx, 6);
        chk("bp_drained", sb.size(), 0);

        // Flush of a full pipe with the sink stalled
        for (int i = 0; i < LAT; i++) step(1'b1, 32'h100 + i, 1'b0, 1'b0);
        chk("pre_flush_occ", occupancy, LAT);
        step(1'b1, 32'h1FF, 1'b1, 1'b0);
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_occ", occupancy, 0);
        chk("flush_taps", tap_valids, '0);
        step(1'b1, 32'h200, 1'b0, 1'b1);
        for (int i = 0; i < LAT + 1; i++) step(1'b0, '0, 1'b0, 1'b1);

        // Random traffic
        for (int c = 0; c < 10000; c++) begin
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 199) == 0,
                 $urandom_range(0, 2) != 0);
        end

        // Asynchronous reset in the middle of a stream
        for (int i = 0; i < 6; i++) step(1'b1, 32'hC000 + i, 1'b0, i[0]);
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_tap_valids", tap_valids, '0);
        chk("rst_tap_datas", tap_datas, '0);
        chk("rst_occ", occupancy, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_outputs();
        for (int i = 0; i < 8; i++) step(1'b1, 32'hB000 + i, 1'b0, 1'b1);
        for (int i = 0; i < LAT + 2; i++) step(1'b0, '0, 1'b0, 1'b1);
        chk("post_rst_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
